// File: rtl/i2c_pkg.sv
// Shared constants and helpers for the I2C core's byte FIFOs.
package i2c_pkg;

    localparam int I2C_DATA_WIDTH = 8;
    localparam int I2C_FIFO_DEPTH = 16;

    // Constant-expression ceil(log2) for tools that mishandle $clog2 in parameter contexts.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/i2c_byte_fifo_if.sv
// Host/master-side bundle of an i2c_byte_fifo. The optional o_peak port exists only
// when I2C_FIFO_PEAK_EN is defined.
interface i2c_byte_fifo_if
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = I2C_DATA_WIDTH,
    parameter int DEPTH      = I2C_FIFO_DEPTH
);
    localparam int CW = clog2(DEPTH) + 1;

    // Push and pop are single-cycle strobes with no ready. A push is taken when the FIFO is not
    // full or a pop is taken in the same cycle. A pop is taken when the FIFO is not empty.
    // Rejected strobes raise the sticky o_overflow/o_underflow flags.
    logic                  i_clear;
    logic                  i_wr_en;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  i_rd_en;
    logic                  i_err_clr;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_empty;
    logic                  o_full;
    logic                  o_almost_empty;
    logic                  o_almost_full;
    logic [CW-1:0]         o_count;
    logic                  o_overflow;
    logic                  o_underflow;
`ifdef I2C_FIFO_PEAK_EN
    logic [CW-1:0]         o_peak;
`endif

    modport master (
        output i_clear, i_wr_en, i_wr_data, i_rd_en, i_err_clr,
        input  o_rd_data, o_empty, o_full, o_almost_empty, o_almost_full,
               o_count, o_overflow, o_underflow
`ifdef I2C_FIFO_PEAK_EN
        , input o_peak
`endif
    );

    modport slave (
        input  i_clear, i_wr_en, i_wr_data, i_rd_en, i_err_clr,
        output o_rd_data, o_empty, o_full, o_almost_empty, o_almost_full,
               o_count, o_overflow, o_underflow
`ifdef I2C_FIFO_PEAK_EN
        , output o_peak
`endif
    );

endinterface

// File: rtl/i2c_fifo_mem.sv
// Simple dual-port register array with a synchronous write port and an asynchronous read port.
module i2c_fifo_mem
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = I2C_DATA_WIDTH,
    parameter int DEPTH      = I2C_FIFO_DEPTH,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/i2c_byte_fifo.sv
// First-word-fall-through byte FIFO between host and i2c_master.
// Define I2C_FIFO_PEAK_EN to add the o_peak occupancy high-water mark.
module i2c_byte_fifo
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH       = I2C_DATA_WIDTH,
    parameter int DEPTH            = I2C_FIFO_DEPTH,
    parameter int ALMOST_FULL_LVL  = 12,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    i2c_byte_fifo_if.slave bus
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LVL);
    localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_LVL);

    logic [AW-1:0]         wr_ptr, wr_ptr_next, rd_ptr, rd_ptr_next;
    logic [CW-1:0]         count, count_next;
    logic                  empty, full, almost_empty, almost_full;
    logic                  overflow, overflow_next, underflow, underflow_next;
    logic                  pop_ok, push_ok, mem_we;
    logic [DATA_WIDTH-1:0] head;

    assign pop_ok  = bus.i_rd_en && !empty;
    assign push_ok = bus.i_wr_en && (!full || pop_ok);
    assign mem_we  = push_ok && !bus.i_clear;

    always_comb begin
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        count_next     = count;
        overflow_next  = overflow;
        underflow_next = underflow;
        if (bus.i_clear) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr_next = rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count_next = count + 1'b1;
            else if (pop_ok && !push_ok) count_next = count - 1'b1;
            // A fresh error outranks a same-cycle err_clr.
            if (bus.i_wr_en && !push_ok) overflow_next = 1'b1;
            else if (bus.i_err_clr)      overflow_next = 1'b0;
            if (bus.i_rd_en && empty)    underflow_next = 1'b1;
            else if (bus.i_err_clr)      underflow_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            empty        <= (count_next == '0);
            full         <= (count_next == FULL_CNT);
            almost_empty <= (count_next <= AE_CNT);
            almost_full  <= (count_next >= AF_CNT);
            overflow     <= overflow_next;
            underflow    <= underflow_next;
        end
    end

    i2c_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (i_clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (bus.i_wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign bus.o_rd_data      = empty ? '0 : head;
    assign bus.o_empty        = empty;
    assign bus.o_full         = full;
    assign bus.o_almost_empty = almost_empty;
    assign bus.o_almost_full  = almost_full;
    assign bus.o_count        = count;
    assign bus.o_overflow     = overflow;
    assign bus.o_underflow    = underflow;

`ifdef I2C_FIFO_PEAK_EN
    logic [CW-1:0] peak, peak_next;

    always_comb begin
        peak_next = peak;
        if (bus.i_clear || bus.i_err_clr) peak_next = '0;
        else if (count_next > peak)       peak_next = count_next;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) peak <= '0;
        else         peak <= peak_next;
    end

    assign bus.o_peak = peak;
`endif

endmodule
